// File: rtl/psram_pkg.sv
// psram_pkg: shared state type and constants for the PSRAM arbiter
package psram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_BUSY_TIMEOUT = 4;
endpackage

// File: rtl/psram_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_grant
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
  output logic [NUM_PORTS-1:0]         grant,
  output logic                         valid
);
  localparam int IW = $clog2(NUM_PORTS);
  logic [IW-1:0] p;
  // scan from lowest to highest priority so the port right after last_grant wins
  always_comb begin
    grant = '0;
    p = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      p = IW'((int'(last_grant) + i) % NUM_PORTS);
      if (req[p]) begin
        grant = '0;
        grant[p] = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin sharing of one PSRAM controller, one transaction in flight
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read_strb,
  output logic                        mem_write_strb,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(WAIT_BUSY_TIMEOUT);
  state_t state;
  logic [IW-1:0] last_grant, gidx;
  logic [NUM_PORTS-1:0] grant;
  logic pick_valid, op_we, sel_we, done;
  logic [TW-1:0] tmo;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req       (req),
    .last_grant(last_grant),
    .grant     (grant),
    .valid     (pick_valid)
  );
  // route the granted port's request fields and index
  always_comb begin
    gidx = '0;
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        gidx = IW'(i);
        sel_we = we[i];
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end
  // op completes on ready returning, or when ready never dropped within the timeout
  assign done = state == WAIT_DONE ? mem_ready :
                state == WAIT_BUSY && mem_ready && tmo == TW'(WAIT_BUSY_TIMEOUT - 1);
  // transaction sequencer with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NUM_PORTS - 1);
      ack <= '0;
      rvalid <= '0;
      rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_read_strb <= 1'b0;
      mem_write_strb <= 1'b0;
      op_we <= 1'b0;
      tmo <= '0;
    end else begin
      ack <= '0;
      rvalid <= '0;
      mem_read_strb <= 1'b0;
      mem_write_strb <= 1'b0;
      case (state)
        IDLE: if (mem_ready && pick_valid) begin
          ack <= grant;
          last_grant <= gidx;
          op_we <= sel_we;
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          state <= ISSUE;
        end
        ISSUE: if (mem_ready) begin
          mem_read_strb <= !op_we;
          mem_write_strb <= op_we;
          tmo <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!mem_ready) state <= WAIT_DONE; else tmo <= tmo + 1'b1;
        default: ;
      endcase
      if (done) begin
        if (!op_we) begin
          rdata <= mem_rdata;
          rvalid[last_grant] <= 1'b1;
        end
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized and directed checks against a transaction-level model
module tb_psram_arbiter;
  localparam int NP = 2, AW = 24, DW = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [NP-1:0] req = '0, we = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic [NP-1:0] ack, rvalid;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic mem_read_strb, mem_write_strb;

  always #5 clk = ~clk;

  psram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_read_strb(mem_read_strb), .mem_write_strb(mem_write_strb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int compared = 0, mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [NP-1:0] v, input int k);
    logic [NP-1:0] m;
    m = v >> k;
    return m[0];
  endfunction

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {4'hA, a[11:0]};
  endfunction

  logic [DW-1:0] ctl_mem [int];
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ctl_rd(input logic [AW-1:0] a);
    return ctl_mem.exists(int'(a)) ? ctl_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] r, input int last);
    for (int i = 1; i <= NP; i++) if (bit_of(r, (last + i) % NP)) return (last + i) % NP;
    return -1;
  endfunction

  // memory controller model: drops ready one cycle after a strobe, busy for a while
  bit ctl_force_low = 0, ctl_never_drop = 0, ctl_rand = 0;
  int ctl_busy = 10;
  initial begin
    logic [AW-1:0] a;
    logic w;
    int busy;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        mem_ready = !ctl_force_low;
        continue;
      end
      if (mem_read_strb || mem_write_strb) begin
        a = mem_addr;
        w = mem_write_strb;
        if (w) ctl_mem[int'(a)] = mem_wdata;
        if (ctl_never_drop) begin
          if (!w) mem_rdata = ctl_rd(a);
        end else begin
          busy = ctl_rand ? int'($urandom_range(0, 6)) : ctl_busy;
          @(posedge clk); #1;
          if (!reset) begin
            mem_ready = 1'b0;
            for (int i = 0; i < busy && !reset; i++) begin
              @(posedge clk); #1;
            end
            if (!w && !reset) mem_rdata = ctl_rd(a);
          end
          mem_ready = 1'b1;
        end
      end else mem_ready = !ctl_force_low;
    end
  end

  // transaction-level model and per-cycle compare
  int cyc = 0, ack_cnt = 0, rv_cnt = 0, strb_cnt = 0, ack_cyc = 0, rv_cyc = 0, rise_cyc = 0;
  int model_last = NP - 1;
  bit has_txn = 0, strb_seen = 0, rv_seen = 0;
  int t_port = 0;
  logic t_we = 1'b0;
  logic [AW-1:0] t_addr = '0, s_addr = '0;
  logic [DW-1:0] t_wdata = '0, s_wdata = '0, exp_rdata = '0;
  logic s_we = 1'b0;
  logic [NP-1:0] p_req = '0, p_we = '0;
  logic [NP*AW-1:0] p_addr = '0;
  logic [NP*DW-1:0] p_wdata = '0;
  logic p_ready = 1'b1;
  int ack_log[$], rv_port_log[$];
  logic [DW-1:0] rv_data_log[$];

  initial begin
    int g;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check("reset_outputs", {ack, rvalid, rdata, mem_addr, mem_wdata, mem_read_strb, mem_write_strb}, 0);
        model_last = NP - 1;
        has_txn = 0;
        exp_rdata = '0;
      end else begin
        if (ack != '0) begin
          ack_cnt++;
          ack_cyc = cyc;
          g = 0;
          for (int i = 0; i < NP; i++) if (bit_of(ack, i)) g = i;
          check("ack_onehot", $countones(ack), 1);
          check("ack_port", g, rr_pick(p_req, model_last));
          check("ack_ready", p_ready, 1);
          if (has_txn) check("prev_done", strb_seen && (t_we || rv_seen), 1);
          has_txn = 1; strb_seen = 0; rv_seen = 0;
          t_port = g;
          t_we = bit_of(p_we, g);
          t_addr = p_addr[g*AW +: AW];
          t_wdata = p_wdata[g*DW +: DW];
          if (t_we) ref_mem[int'(t_addr)] = t_wdata;
          model_last = g;
          ack_log.push_back(g);
        end
        if (mem_read_strb || mem_write_strb) begin
          strb_cnt++;
          check("strobe_single", mem_read_strb & mem_write_strb, 0);
          check("strobe_ready", mem_ready, 1);
          check("strobe_txn", has_txn && !strb_seen, 1);
          check("strobe_op", {mem_write_strb, mem_addr}, {t_we, t_addr});
          if (t_we) check("strobe_wdata", mem_wdata, t_wdata);
          strb_seen = 1;
          s_addr = mem_addr; s_we = mem_write_strb; s_wdata = mem_wdata;
        end
        if (rvalid != '0) begin
          rv_cnt++;
          rv_cyc = cyc;
          g = 0;
          for (int i = 0; i < NP; i++) if (bit_of(rvalid, i)) g = i;
          check("rv_onehot", $countones(rvalid), 1);
          check("rv_txn", has_txn && !t_we && strb_seen && !rv_seen && g == t_port, 1);
          exp_rdata = ref_rd(t_addr);
          rv_seen = 1;
          rv_port_log.push_back(g);
          rv_data_log.push_back(rdata);
        end
        check("rdata", rdata, exp_rdata);
        if (!p_ready && mem_ready) rise_cyc = cyc;
      end
      p_req = req; p_we = we; p_addr = addr; p_wdata = wdata; p_ready = mem_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
    we = (we & ~(NP'(1) << p)) | (NP'(w) << p);
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    req = (req & ~(NP'(1) << p)) | (NP'(r) << p);
  endtask

  task automatic wait_cnt(input bit rv, input int n, input int budget, input string name);
    int k = 0;
    while ((rv ? rv_cnt : ack_cnt) < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, (rv ? rv_cnt : ack_cnt) >= n, 1);
  endtask

  task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int a0, r0;
    a0 = ack_cnt; r0 = rv_cnt;
    @(posedge clk); #1;
    set_port(p, w, a, d, 1'b1);
    wait_cnt(0, a0 + 1, 60, "ack_wait");
    @(posedge clk); #1;
    set_port(p, w, a, d, 1'b0);
    if (!w) wait_cnt(1, r0 + 1, 60, "rvalid_wait");
    else repeat (20) @(posedge clk);
  endtask

  initial begin
    int a0, r0, s0, k;
    ctl_mem[0] = 16'h1234;
    ref_mem[0] = 16'h1234;
    repeat (3) @(posedge clk); #1;
    check("reset_state", {ack, rvalid, rdata, mem_addr, mem_wdata, mem_read_strb, mem_write_strb}, 0);
    reset = 1'b0;
    // single read on port 0
    s0 = strb_cnt;
    txn(0, 1'b0, 24'h000000, 16'h0);
    check("t1_ack_port", ack_log[$], 0);
    check("t1_strobes", strb_cnt - s0, 1);
    check("t1_strobe", {s_we, s_addr}, {1'b0, 24'h000000});
    check("t1_rv", {rv_port_log[$], rv_data_log[$]}, {32'd0, 16'h1234});
    check("t1_rdata_hold", rdata, 16'h1234);
    // single write on port 1, then read it back on port 1
    s0 = strb_cnt; r0 = rv_cnt;
    txn(1, 1'b1, 24'h000002, 16'h5678);
    check("t2_ack_port", ack_log[$], 1);
    check("t2_strobe", {s_we, s_addr, s_wdata}, {1'b1, 24'h000002, 16'h5678});
    check("t2_strobes", strb_cnt - s0, 1);
    check("t2_no_rvalid", rv_cnt, r0);
    txn(1, 1'b0, 24'h000002, 16'h0);
    check("t2_readback", {rv_port_log[$], rv_data_log[$]}, {32'd1, 16'h5678});
    // both ports reading continuously
    a0 = ack_cnt; r0 = rv_cnt;
    @(posedge clk); #1;
    set_port(0, 1'b0, 24'h000004, 16'h0, 1'b1);
    set_port(1, 1'b0, 24'h000005, 16'h0, 1'b1);
    wait_cnt(0, a0 + 6, 400, "t3_acks");
    @(posedge clk); #1;
    req = '0;
    wait_cnt(1, r0 + 6, 100, "t3_rvalids");
    for (int i = 0; i < 6; i++) begin
      check("t3_order", ack_log[a0 + i], i % 2);
      check("t3_data", rv_data_log[r0 + i], (i % 2) != 0 ? 16'hA005 : 16'hA004);
    end
    // ready held low after reset
    @(posedge clk); #1;
    reset = 1'b1; ctl_force_low = 1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    a0 = ack_cnt; s0 = strb_cnt; r0 = rv_cnt;
    set_port(0, 1'b0, 24'h000003, 16'h0, 1'b1);
    repeat (200) @(posedge clk);
    check("t4_no_ack", ack_cnt, a0);
    check("t4_no_strobe", strb_cnt, s0);
    @(negedge clk);
    ctl_force_low = 0;
    wait_cnt(0, a0 + 1, 10, "t4_ack");
    check("t4_ack_latency", ack_cyc - rise_cyc, 1);
    check("t4_ack_port", ack_log[$], 0);
    @(posedge clk); #1;
    req = '0;
    wait_cnt(1, r0 + 1, 60, "t4_rvalid");
    check("t4_data", rv_data_log[$], 16'hA003);
    // controller that never drops ready
    @(posedge clk); #1;
    ctl_never_drop = 1;
    txn(0, 1'b0, 24'h000007, 16'h0);
    check("t5_data", {rv_port_log[$], rv_data_log[$]}, {32'd0, 16'hA007});
    check("t5_timeout_latency", rv_cyc - ack_cyc, 5);
    @(posedge clk); #1;
    ctl_never_drop = 0;
    repeat (5) @(posedge clk);
    // reset while waiting for the controller
    a0 = ack_cnt; r0 = rv_cnt;
    @(posedge clk); #1;
    set_port(0, 1'b0, 24'h000008, 16'h0, 1'b1);
    wait_cnt(0, a0 + 1, 20, "t6_ack");
    @(posedge clk); #1;
    req = '0;
    k = 0;
    while (mem_ready && k < 20) begin @(negedge clk); k++; end
    check("t6_busy_seen", mem_ready, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    set_port(0, 1'b0, 24'h000009, 16'h0, 1'b1);
    set_port(1, 1'b0, 24'h00000A, 16'h0, 1'b1);
    #1;
    check("t6_reset_now", {ack, rvalid, rdata, mem_addr, mem_wdata, mem_read_strb, mem_write_strb}, 0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    a0 = ack_cnt;
    wait_cnt(0, a0 + 2, 100, "t6_acks");
    @(posedge clk); #1;
    req = '0;
    wait_cnt(1, r0 + 2, 60, "t6_rvalids");
    check("t6_first_port", ack_log[a0], 0);
    check("t6_second_port", ack_log[a0 + 1], 1);
    check("t6_rv_count", rv_cnt - r0, 2);
    check("t6_data0", rv_data_log[r0], 16'hA009);
    check("t6_data1", rv_data_log[r0 + 1], 16'hA00A);
    // randomized traffic with random controller latency
    ctl_rand = 1;
    a0 = ack_cnt;
    repeat (800) begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (bit_of(ack, p)) begin
          if ($urandom_range(0, 1) != 0)
            set_port(p, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 15)), 16'($urandom), 1'b1);
          else set_port(p, bit_of(we, p), addr[p*AW +: AW], wdata[p*DW +: DW], 1'b0);
        end else if (!bit_of(req, p) && $urandom_range(0, 3) == 0)
          set_port(p, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 15)), 16'($urandom), 1'b1);
        else if (bit_of(req, p) && $urandom_range(0, 40) == 0)
          set_port(p, bit_of(we, p), addr[p*AW +: AW], wdata[p*DW +: DW], 1'b0);
      end
    end
    @(posedge clk); #1;
    req = '0;
    repeat (60) @(posedge clk);
    check("t7_progress", ack_cnt - a0 > 10, 1);
    check("t7_drained", !has_txn || (strb_seen && (t_we || rv_seen)), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
